sha256_msg_padder: RTL
======================

# sha256_msg_padder

Streaming SHA-256 pre-processor that sits upstream of the message scheduler. It accepts the message as 32-bit big-endian words over a valid/ready handshake and applies FIPS 180-4 padding: a 0x80 marker byte, zero fill, and a 64-bit bit-length field. It emits complete 512-bit blocks over a second valid/ready handshake, ready to drive the scheduler's 512-bit block input. It also flags the final block of each message.

## Interface
Parameters:
- LEN_W, 64, width of the internal bit-length counter (≤64); zero-extended into the 64-bit length field.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_i  in  1  asynchronous, active-high reset.
- data_i  in  32  message word; byte 0 of the word is in [31:24].
- valid_i  in  1  data_i qualifier.
- last_i  in  1  data_i is the final word of the message.
- bytes_i  in  2  valid bytes in the final word, minus 1 (3 = full word); MSB-aligned; sampled only with last_i.
- ready_o  out  1  padder accepts a word this cycle.
- block_o  out  512  padded block; W0 in [511:480], W15 in [31:0].
- block_valid_o  out  1  block_o is valid.
- block_ready_i  in  1  downstream accepts the block.
- block_last_o  out  1  current block is the message's final block.

## Operation
- Internal storage: 16×32 slot buffer, 4-bit slot index `s`, LEN_W-bit bit counter, FSM with states ACCEPT, FILL, EMIT.
- ACCEPT: ready_o=1. On valid_i&ready_o, data_i is written to slot s and s increments.
  - Not last: the counter adds 32. If s was 15, go to EMIT with block_last_o=0.
  - Last with bytes_i<3: slot s receives the valid bytes, then 0x80, then zero bytes. The counter adds (bytes_i+1)*8.
  - Last with bytes_i==3: the word is stored unchanged, the counter adds 32, and 0x80000000 is pending for the next slot.
  - After any last word, go to FILL, or go to EMIT if the buffer just filled.
- FILL: ready_o=0. Writes one slot per cycle, in order:
  - the pending marker if any;
  - zeros through slot 13;
  - counter[63:32] in slot 14 and counter[31:0] in slot 15, but only if the marker ended in slot ≤13. Otherwise slots fill with zeros to 15, the block emits with block_last_o=0, and FILL resumes at slot 0 of a fresh block.
  - After slot 15 is written, go to EMIT.
- EMIT: block_valid_o=1 and block_o stable until block_valid_o&block_ready_i. On handshake:
  - go back to FILL if padding or length is still owed;
  - otherwise go to ACCEPT with s=0.
  - The counter clears after a block_last_o=1 handshake.
- block_last_o=1 only on the block that carries the length field.
- Length arithmetic is modulo 2^LEN_W and wraps silently.
- valid_i while ready_o=0 is ignored; the word is not consumed.

## Timing
- While reset_i is high and on release: state=ACCEPT, s=0, counter=0, buffer=0, block_o=0, block_valid_o=0, block_last_o=0.
  - ready_o is decoded from state and forced to 0 while reset_i is high. It is 1 in the first cycle after release.
- Non-last word in slot 15: block_valid_o rises in the cycle after the handshake.
- Last word in slot s (fits case): FILL writes slots s+1..15 over 15−s cycles. block_valid_o rises in the cycle after slot 15 is written, i.e. 16−s cycles after the handshake (1 cycle if s=15).
- Overflow case: the second block's block_valid_o rises 17 cycles after the first block's handshake.
- block_ready_i low holds EMIT indefinitely with no change to any output.
- Reset asserted mid-message or mid-EMIT: the partial block and count are discarded and the block is never emitted.

## Configuration
- SHA256_PADDER_BYTE_EN defined: bytes_i is honoured as above. Messages may be any whole number of bytes.
- SHA256_PADDER_BYTE_EN undefined: bytes_i is ignored and treated as 3. Messages are whole words; the partial-word insertion logic is removed.

## Test plan
- "abc": data_i=0x61626300, last_i=1, bytes_i=2 -> one block with W0=0x61626380, W1..W14=0, W15=0x00000018, block_last_o=1. After the scheduler and compressor, the digest is 0xba7816bf…f20015ad.
- 16 full words, word 15 with last_i=1 -> block 1 = raw data, last=0; block 2 = W0=0x80000000, W1..W14=0, W15=0x00000200, last=1, valid 17 cycles after block 1 handshake.
- 14 full words, last on word 13 -> block 1 has W14=0x80000000, W15=0, last=0; block 2 has W0..W14=0, W15=0x000001C0, last=1.
- block_ready_i held low 20 cycles during EMIT -> block_o and block_valid_o stable; ready_o=0; valid_i words are not consumed.
- reset_i pulsed after 5 words, then "abc" -> only the "abc" block is produced, with W15=0x18.
- Without SHA256_PADDER_BYTE_EN: 1 word, last_i=1, bytes_i=0 -> W1=0x80000000, W15=0x20.

Source files
------------

// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 padder: packs 32-bit big-endian words into padded 512-bit blocks.
// Optional SHA256_PADDER_BYTE_EN: honour bytes_i on the final word; without it messages are whole words.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic [31:0]  data_i,
    input  logic         valid_i,
    input  logic         last_i,
    input  logic [1:0]   bytes_i,
    output logic         ready_o,
    output logic [511:0] block_o,
    output logic         block_valid_o,
    input  logic         block_ready_i,
    output logic         block_last_o
);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_FILL   = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       slot_q;
    logic [LEN_W-1:0] len_q;
    logic [31:0]      buf_q [16];
    logic             mark_pend_q;
    logic             len_here_q;
    logic             msg_done_q;
    logic             valid_q;
    logic             last_q;

    logic [1:0]       bytes_s;
    logic [31:0]      last_word_s;
    logic [5:0]       last_bits_s;
    logic [LEN_W-1:0] last_add_s;
    logic [63:0]      len_ext_s;
    logic [31:0]      fill_word_s;
    logic             len_here_d;

`ifdef SHA256_PADDER_BYTE_EN
    function automatic logic [31:0] pad_partial(input logic [31:0] word, input logic [1:0] nbm1);
        logic [31:0] res;
        case (nbm1)
            2'd0:    res = {word[31:24], 8'h80, 16'h0000};
            2'd1:    res = {word[31:16], 8'h80, 8'h00};
            2'd2:    res = {word[31:8], 8'h80};
            default: res = word;
        endcase
        return res;
    endfunction

    assign bytes_s     = bytes_i;
    assign last_word_s = pad_partial(data_i, bytes_i);
`else
    logic unused_bytes_s;
    assign unused_bytes_s = ^bytes_i;
    assign bytes_s        = 2'd3;
    assign last_word_s    = data_i;
`endif

    assign last_bits_s   = {1'b0, bytes_s, 3'b000} + 6'd8;
    assign last_add_s    = LEN_W'(last_bits_s);
    assign len_ext_s     = 64'(len_q);
    // The length fits in this block only if the marker landed at or before slot 13.
    assign len_here_d    = mark_pend_q ? (slot_q <= 4'd13) : len_here_q;
    assign ready_o       = (state_q == ST_ACCEPT) && !reset_i;
    assign block_valid_o = valid_q;
    assign block_last_o  = last_q;

    // Select the word FILL writes into the current slot.
    always_comb begin
        fill_word_s = 32'h0000_0000;
        if (mark_pend_q) begin
            fill_word_s = 32'h8000_0000;
        end else if (len_here_q && (slot_q == 4'd14)) begin
            fill_word_s = len_ext_s[63:32];
        end else if (len_here_q && (slot_q == 4'd15)) begin
            fill_word_s = len_ext_s[31:0];
        end else begin
            fill_word_s = 32'h0000_0000;
        end
    end

    // Present the slot buffer as the block, W0 in the top word.
    always_comb begin
        block_o = {512{1'b0}};
        for (int i = 0; i < 16; i++) begin
            block_o[511 - 32*i -: 32] = buf_q[i];
        end
    end

    // Control FSM together with slot buffer, bit counter and registered block flags.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_ACCEPT;
            slot_q      <= 4'd0;
            len_q       <= {LEN_W{1'b0}};
            mark_pend_q <= 1'b0;
            len_here_q  <= 1'b0;
            msg_done_q  <= 1'b0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 32'h0000_0000;
            end
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (valid_i) begin
                        slot_q <= slot_q + 4'd1;
                        if (!last_i) begin
                            buf_q[slot_q] <= data_i;
                            len_q         <= len_q + LEN_W'(6'd32);
                            if (slot_q == 4'd15) begin
                                state_q    <= ST_EMIT;
                                valid_q    <= 1'b1;
                                last_q     <= 1'b0;
                                msg_done_q <= 1'b0;
                            end
                        end else begin
                            buf_q[slot_q] <= last_word_s;
                            len_q         <= len_q + last_add_s;
                            msg_done_q    <= 1'b1;
                            mark_pend_q   <= (bytes_s == 2'd3);
                            len_here_q    <= (slot_q <= 4'd13);
                            if (slot_q == 4'd15) begin
                                state_q <= ST_EMIT;
                                valid_q <= 1'b1;
                                last_q  <= 1'b0;
                            end else begin
                                state_q <= ST_FILL;
                            end
                        end
                    end
                end
                ST_FILL: begin
                    buf_q[slot_q] <= fill_word_s;
                    slot_q        <= slot_q + 4'd1;
                    mark_pend_q   <= 1'b0;
                    len_here_q    <= len_here_d;
                    if (slot_q == 4'd15) begin
                        state_q <= ST_EMIT;
                        valid_q <= 1'b1;
                        last_q  <= len_here_d;
                    end
                end
                ST_EMIT: begin
                    if (block_ready_i) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        slot_q  <= 4'd0;
                        if (last_q) begin
                            state_q    <= ST_ACCEPT;
                            len_q      <= {LEN_W{1'b0}};
                            msg_done_q <= 1'b0;
                        end else if (msg_done_q) begin
                            // Padding spilled past this block; a fresh block always has room for the length.
                            state_q    <= ST_FILL;
                            len_here_q <= 1'b1;
                        end else begin
                            state_q <= ST_ACCEPT;
                        end
                    end
                end
                default: begin
                    state_q <= ST_ACCEPT;
                end
            endcase
        end
    end

endmodule
